// File: rtl/add64_stream_seq_pkg.sv
// add_pkg: widths, beat count and FSM states shared by the streaming adder slice.
package add_pkg;
    localparam int DATA_W = 64;
    localparam int BEAT_W = 16;
    localparam int NBEATS = DATA_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, SEND} state_t;
endpackage

// File: rtl/add64_stream_seq_if.sv
// add64_stream_seq_if: operand input stream and result output stream.
interface add64_stream_seq_if
    import add_pkg::*;
();
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic              out_last;
    logic              out_cout;
    modport master (
        output in_valid, in_data, in_cin, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_cout
    );
    modport slave (
        input  in_valid, in_data, in_cin, out_ready,
        output in_ready, out_valid, out_data, out_last, out_cout
    );
endinterface

// File: rtl/add64_stream_seq_rca.sv
// RCA_64bit: 64-bit ripple-carry adder built from a chain of full adders.
module RCA_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [64:0] c;
    assign c[0] = cin;
    assign cout = c[64];
    genvar i;
    for (i = 0; i < 64; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

// File: rtl/add64_stream_seq.sv
// add64_stream_seq: collects A and B as narrow beats, adds them in one cycle,
// and streams the 64-bit sum back out least-significant beat first.
module add64_stream_seq
    import add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    add64_stream_seq_if.slave bus,
    output logic              busy
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_reg, b_reg, sum_reg, sum;
    logic               cin_reg, cout_reg, cout;
    logic               in_hs, out_hs, last;

    // rst_n gates the decoded outputs so everything reads 0 during reset
    assign bus.in_ready  = rst_n & (state == LOAD_A || state == LOAD_B);
    assign bus.out_valid = rst_n & (state == SEND);
    assign bus.out_data  = bus.out_valid ? sum_reg[cnt*BEAT_W +: BEAT_W] : '0;
    assign bus.out_last  = bus.out_valid & last;
    assign bus.out_cout  = bus.out_last & cout_reg;
    assign busy          = rst_n & (state == ADD || state == SEND);
    assign in_hs         = bus.in_valid & bus.in_ready;
    assign out_hs        = bus.out_valid & bus.out_ready;
    assign last          = cnt == CNT_W'(NBEATS - 1);

    RCA_64bit u_rca (
        .a    (a_reg),
        .b    (b_reg),
        .cin  (cin_reg),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD_A;
            cnt   <= '0;
        end else begin
            case (state)
                LOAD_A: if (in_hs) begin
                    cnt <= last ? '0 : cnt + CNT_W'(1);
                    if (last) state <= LOAD_B;
                end
                LOAD_B: if (in_hs) begin
                    cnt <= last ? '0 : cnt + CNT_W'(1);
                    if (last) state <= ADD;
                end
                ADD: begin
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: if (out_hs) begin
                    cnt <= last ? '0 : cnt + CNT_W'(1);
                    if (last) state <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            cin_reg  <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            if (in_hs && state == LOAD_A) a_reg[cnt*BEAT_W +: BEAT_W] <= bus.in_data;
            if (in_hs && state == LOAD_B) b_reg[cnt*BEAT_W +: BEAT_W] <= bus.in_data;
            if (in_hs && state == LOAD_B && last) cin_reg <= bus.in_cin;
            if (state == ADD) begin
                sum_reg  <= sum;
                cout_reg <= cout;
            end
        end
    end
endmodule

// File: tb/tb_add64_stream_seq.sv
// tb_add64_stream_seq: randomized and directed operations scored against a
// plain-arithmetic model through a queue drained by an output monitor.
module tb_add64_stream_seq;
    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        c;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   total = 0;
    int   bad = 0;
    beat_t exp_q[$];
    int   beat_i = 0;
    int   stall_left = 3;
    bit   stall_mode = 0;
    bit   rand_ready = 0;

    add64_stream_seq_if bus ();

    add64_stream_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        beat_i = 0;
        stall_left = 3;
    endtask

    // Output monitor: compares every presented beat, owns out_ready.
    initial begin
        beat_t e;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
                chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
                chk("rst_out_data", {48'b0, bus.out_data}, 64'd0);
                chk("rst_out_last_cout", {62'b0, bus.out_last, bus.out_cout}, 64'd0);
                chk("rst_busy", {63'b0, busy}, 64'd0);
                bus.out_ready = 1'b1;
            end else begin
                if (busy) chk("no_overlap_in_ready", {63'b0, bus.in_ready}, 64'd0);
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=%h expected=none t=%0t", bus.out_data, $time);
                        bus.out_ready = 1'b1;
                    end else begin
                        e = exp_q[0];
                        chk("out_data", {48'b0, bus.out_data}, {48'b0, e.d});
                        chk("out_last", {63'b0, bus.out_last}, {63'b0, e.l});
                        chk("out_cout", {63'b0, bus.out_cout}, {63'b0, e.c});
                        if (stall_mode && beat_i == 1 && stall_left > 0) begin
                            bus.out_ready = 1'b0;
                            stall_left--;
                        end else begin
                            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                        end
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            beat_i = (beat_i + 1) % 4;
                            if (beat_i == 0) stall_left = 3;
                        end
                    end
                end else begin
                    bus.out_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic c, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_cin   = c;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_cin   = 1'($urandom);
    endtask

    // Model: 65-bit sum split into beats; only the final B beat carries cin.
    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input bit gaps, input int nbeats, input bit noise, input bit lat);
        logic [64:0] r;
        logic [127:0] ab;
        r  = {1'b0, a} + {1'b0, b} + 65'(cin);
        ab = {b, a};
        for (int k = 0; k < nbeats; k++) begin
            if (k == 7)
                for (int j = 0; j < 4; j++)
                    exp_q.push_back('{r[16*j +: 16], j == 3, (j == 3) & r[64]});
            send_beat(ab[16*k +: 16], (k == 7) ? cin : (noise ? 1'b1 : 1'($urandom)), gaps);
        end
        if (lat) begin
            @(negedge clk);
            chk("lat_add_busy", {63'b0, busy}, 64'd1);
            chk("lat_add_no_valid", {63'b0, bus.out_valid}, 64'd0);
            @(negedge clk);
            chk("lat_first_valid", {63'b0, bus.out_valid}, 64'd1);
            repeat (3) @(negedge clk);
            chk("lat_last_at_t5", {63'b0, bus.out_last}, 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush();
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'b0, bus.in_ready}, 64'd1);
        chk("no_valid_after_rst", {63'b0, bus.out_valid}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] BA = 64'h0000_0000_0123_cdef;
    localparam logic [63:0] BB = 64'h1234_5678_9abc_def0;

    initial begin
        int n;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_cin   = 1'b0;
        do_reset(3);
        op(BA, BB, 1'b0, 0, 8, 0, 1);
        drain();
        op(64'hffff_ffff_ffff_ffff, 64'd0, 1'b1, 0, 8, 0, 0);
        drain();
        op(64'd1, 64'hffff_ffff_ffff_ffff, 1'b0, 0, 8, 1, 0);
        drain();
        stall_mode = 1;
        stall_left = 3;
        op(BA, BB, 1'b0, 1, 8, 0, 0);
        drain();
        stall_mode = 0;
        op(BA, BB, 1'b1, 0, 5, 0, 0);
        do_reset(1);
        op(64'd2, 64'd3, 1'b0, 0, 8, 0, 0);
        drain();
        op(BA, BB, 1'b0, 0, 8, 0, 0);
        n = 0;
        @(negedge clk);
        #1;
        while (!(bus.out_valid && beat_i == 2) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("wait_second_beat_timeout", 64'd0, 64'd1);
        rst_n = 1'b0;
        flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("send_rst_no_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("send_rst_ready", {63'b0, bus.in_ready}, 64'd1);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        rand_ready = 1;
        for (int t = 0; t < 20; t++) begin
            logic [63:0] a, b;
            a = (t % 5 == 0) ? 64'hffff_ffff_ffff_ffff : {$urandom, $urandom};
            b = (t % 7 == 0) ? 64'd0 : {$urandom, $urandom};
            op(a, b, 1'($urandom), 1, 8, 0, 0);
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add64_stream_seq.md
# add64_stream_seq

Streaming front/back end for the 64-bit ripple-carry adder `RCA_64bit`.
- Accepts operand A and then operand B as narrow beats on a valid/ready input stream.
- Presents the full operands and carry-in to the adder, then registers the 64-bit sum and carry-out.
- Returns the result as narrow beats on a valid/ready output stream.
- Narrow-bus sources and sinks can therefore drive the combinational adder without holding 129 wide inputs.

## Interface
- DATA_W, 64, operand/sum width; must equal 64 to match `RCA_64bit`
- BEAT_W, 16, stream beat width; DATA_W must be an integer multiple of BEAT_W
- NBEATS, DATA_W/BEAT_W (derived, 4), beats per operand/result

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  source has a beat on in_data
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  BEAT_W  operand beat, least-significant beat first
- in_cin  in  1  carry-in, sampled only with the final B beat
- out_valid  out  1  result beat present
- out_ready  in  1  sink accepts result beat
- out_data  out  BEAT_W  sum beat, least-significant beat first
- out_last  out  1  high on final result beat
- out_cout  out  1  carry-out, valid only when out_last=1, else 0
- busy  out  1  high in ADD or SEND

## Operation
The FSM has four states: LOAD_A, LOAD_B, ADD, SEND. A 2-bit beat counter `cnt` counts 0..NBEATS-1.

- **LOAD_A**
  - in_ready=1.
  - On each handshake (in_valid & in_ready), write in_data to a_reg[cnt*BEAT_W +: BEAT_W].
  - Handshake with cnt=NBEATS-1: cnt→0, state→LOAD_B.
- **LOAD_B**
  - Same as LOAD_A, writing b_reg.
  - The final handshake also captures in_cin into cin_reg; state→ADD.
- **ADD**
  - in_ready=0.
  - a_reg, b_reg and cin_reg drive `RCA_64bit`.
  - At the end of the cycle, sum_reg←sum and cout_reg←cout; state→SEND, cnt=0.
- **SEND**
  - out_valid=1, out_data=sum_reg[cnt*BEAT_W +: BEAT_W].
  - out_last=(cnt==NBEATS-1); out_cout=cout_reg & out_last.
  - On out_valid & out_ready: cnt++.
  - The handshake on the last beat sends state→LOAD_A, cnt→0.
- **Arithmetic**
  - sum = (A + B + cin) mod 2^64; cout = bit 64 of the 65-bit result.
  - No signed interpretation and no overflow flag.
- **Boundary conditions**
  - No operand overlap: in_ready stays 0 throughout ADD and SEND.
  - in_valid while in_ready=0 is ignored; it is not an error.
  - in_cin is ignored on every beat except the final B beat.
  - Backpressure: out_data, out_last and out_cout hold stable while out_valid=1 and out_ready=0.
  - Gaps (in_valid=0) in the middle of an operand are legal; partial operand registers hold their contents.
- **Reset**
  - Reset is synchronous and overrides everything, including mid-operation.
  - Reset sends the FSM to LOAD_A, cnt=0, and clears a_reg, b_reg, cin_reg, sum_reg and cout_reg to 0.
  - Any partial operand or unsent result is discarded.

## Timing
- **Output values in the reset cycle and the cycle after:** in_ready=0 while rst_n=0, and 1 in the first cycle after release (LOAD_A). out_valid, out_data, out_last, out_cout and busy are all 0.
- **Latency:** the final B handshake occurs at cycle T. ADD is at T+1. The first out_valid=1 is at T+2. With out_ready held at 1, out_last is at T+5.
- **Throughput:** the minimum operation period is 2·NBEATS+1+NBEATS = 13 cycles.
- **Outputs are registered or decoded from registered state only.** There is no combinational path from in_valid/out_ready to in_ready/out_valid.
- **The adder path is a single-cycle combinational ripple.** The ADD state exists to give it one full clock period.

## Structure
- **Shared package, add_pkg:**
  - DATA_W and BEAT_W defaults
  - state enum {LOAD_A, LOAD_B, ADD, SEND}
  - NBEATS localparam
- **Sub-module:** a single instance of the existing `RCA_64bit`, inputs a_reg, b_reg, cin_reg. No other sub-modules.
- **Counter and FSM** share one always block. Operand and result registers live in a second always block.

## Test plan
- **Basic add:**
  - Stimulus: A beats cdef, 0123, 0000, 0000; B beats def0, 9abc, 5678, 1234; cin=0.
  - Response: out beats acdf, 9be0, 5678, 1234 (sum 0x123456789be0acdf); out_cout=0 on out_last.
- **Full carry ripple:**
  - Stimulus: A=0xffff_ffff_ffff_ffff, B=0, cin=1.
  - Response: four beats 0000; out_cout=1.
- **Carry-in ignored except on the final B beat:**
  - Stimulus: A=1, B=0xffff_ffff_ffff_ffff, with in_cin=1 on every beat except the last B beat.
  - Response: sum 0, out_cout=1 (carry from A+B only).
- **Backpressure and gaps:**
  - Stimulus: same as the basic add, with random in_valid gaps and out_ready low for 3 cycles on beat 2.
  - Response: identical beats; out_data held stable during the stall; in_ready=0 throughout ADD/SEND.
- **Reset mid-load:**
  - Stimulus: after 5 accepted beats, drive rst_n=0 for 1 cycle, then send a fresh A=2, B=3, cin=0.
  - Response: in_ready=0 during reset; result beats 0005, 0000, 0000, 0000; out_cout=0.
- **Reset mid-send:**
  - Stimulus: assert rst_n on the 2nd result beat.
  - Response: out_valid=0 on the next cycle; in_ready=1 after release; no stale beats emitted.
